// File: rtl/wide_add_sequencer_pkg.sv
// rtl/wide_add_sequencer_pkg.sv - shared constants, state type and helpers for the wide add sequencer
package wide_add_pkg;

   localparam int LIMB_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   // Width of the limb index; never narrower than one bit
   function automatic int idx_width(input int limbs);
      return (limbs > 1) ? $clog2(limbs) : 1;
   endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// rtl/wide_add_sequencer_if.sv - request/result handshake bundle between requester and sequencer
interface wide_add_sequencer_if
   import wide_add_pkg::*;
#(
   parameter int LIMBS = 4
);
   logic                      in_valid;
   logic                      in_ready;
   logic                      in_sub;
   logic [LIMBS*LIMB_W-1:0]   in_a;
   logic [LIMBS*LIMB_W-1:0]   in_b;
   logic                      out_valid;
   logic                      out_ready;
   logic [LIMBS*LIMB_W-1:0]   out_y;
   logic                      out_cout;
   logic                      out_ovf;

   modport master (
      output in_valid, in_sub, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_y, out_cout, out_ovf
   );

   modport slave (
      input  in_valid, in_sub, in_a, in_b, out_ready,
      output in_ready, out_valid, out_y, out_cout, out_ovf
   );
endinterface

// File: rtl/prefix_adder_32bit.sv
// rtl/prefix_adder_32bit.sv - 32-bit Kogge-Stone parallel-prefix adder with carry in/out
module prefix_adder_32bit (
   input  logic        cin,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y,
   output logic        cout
);
   logic [31:0] g0;
   logic [31:0] p0;
   logic [31:0] grp_g;
   logic [31:0] grp_p;
   logic [31:0] carry;

   assign g0 = a & b;
   assign p0 = a ^ b;

   // Five doubling levels; after level l each bit covers a span of 2^(l+1) bits ending at itself
   for (genvar l = 0; l < 5; l++) begin : lvl
      logic [31:0] gi;
      logic [31:0] pi;
      logic [31:0] g;
      logic [31:0] p;
      if (l == 0) begin : src_first
         assign gi = g0;
         assign pi = p0;
      end else begin : src_prev
         assign gi = lvl[l-1].g;
         assign pi = lvl[l-1].p;
      end
      assign g = gi | (pi & (gi << (1 << l)));
      assign p = pi & ((pi << (1 << l)) | ((32'd1 << (1 << l)) - 32'd1));
   end

   assign grp_g = lvl[4].g;
   assign grp_p = lvl[4].p;

   // carry[i] is the carry out of bit i, folding the external carry in through the full-span propagate
   assign carry = grp_g | (grp_p & {32{cin}});
   assign y     = p0 ^ {carry[30:0], cin};
   assign cout  = carry[31];

endmodule

// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - sequences one 32-bit prefix adder over LIMBS limbs, LSB first
module wide_add_sequencer
   import wide_add_pkg::*;
#(
   parameter int LIMBS = 4
)(
   input  logic                 clk,
   input  logic                 rst,
   wide_add_sequencer_if.slave  bus
);
   localparam int W  = LIMBS * LIMB_W;
   localparam int IW = idx_width(LIMBS);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_RUN  = RUN;
   localparam logic [1:0] ST_DONE = DONE;

   localparam logic [IW-1:0] LAST_IDX = IW'(LIMBS - 1);

   logic [1:0]        state;
   logic [IW-1:0]     idx;
   logic              carry;
   logic [W-1:0]      a_reg;
   logic [W-1:0]      b_reg;
   logic [W-1:0]      y_reg;
   logic              cout_reg;
   logic              ovf_reg;
   logic              in_ready_reg;
   logic              out_valid_reg;

   logic [LIMB_W-1:0] limb_a;
   logic [LIMB_W-1:0] limb_b;
   logic [LIMB_W-1:0] limb_y;
   logic              limb_cout;
   logic              last_limb;

   assign limb_a    = a_reg[idx*LIMB_W +: LIMB_W];
   assign limb_b    = b_reg[idx*LIMB_W +: LIMB_W];
   assign last_limb = (idx == LAST_IDX);

   prefix_adder_32bit u_adder (
      .cin  (carry),
      .a    (limb_a),
      .b    (limb_b),
      .y    (limb_y),
      .cout (limb_cout)
   );

   // Controller: capture operands, walk the limbs with a chained carry, hold the result until taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         idx           <= '0;
         carry         <= 1'b0;
         a_reg         <= '0;
         b_reg         <= '0;
         y_reg         <= '0;
         cout_reg      <= 1'b0;
         ovf_reg       <= 1'b0;
         in_ready_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid && in_ready_reg) begin
                  // Subtract is a + ~b + 1: invert b once here and seed the carry with in_sub
                  a_reg        <= bus.in_a;
                  b_reg        <= bus.in_sub ? ~bus.in_b : bus.in_b;
                  carry        <= bus.in_sub;
                  idx          <= '0;
                  state        <= ST_RUN;
                  in_ready_reg <= 1'b0;
               end else begin
                  in_ready_reg <= 1'b1;
               end
            end
            ST_RUN: begin
               y_reg[idx*LIMB_W +: LIMB_W] <= limb_y;
               carry                       <= limb_cout;
               idx                         <= idx + 1'b1;
               if (last_limb) begin
                  cout_reg      <= limb_cout;
                  ovf_reg       <= (a_reg[W-1] == b_reg[W-1]) && (limb_y[LIMB_W-1] != a_reg[W-1]);
                  idx           <= '0;
                  state         <= ST_DONE;
                  out_valid_reg <= 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  state         <= ST_IDLE;
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
               end
            end
            default: begin
               state         <= ST_IDLE;
               in_ready_reg  <= 1'b0;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_reg;
   assign bus.out_valid = out_valid_reg;
   assign bus.out_y     = y_reg;
   assign bus.out_cout  = cout_reg;
   assign bus.out_ovf   = ovf_reg;

endmodule
